// File: rtl/color_defs_pkg.sv
// Shared encodings for the colour sensor front end: filter select codes,
// FSM states and colour index, plus the colour-to-filter mapping.
package color_defs;

    // Sensor filter select, packed as {s2, s3}
    localparam logic [1:0] FILTER_RED   = 2'b00;
    localparam logic [1:0] FILTER_GREEN = 2'b11;
    localparam logic [1:0] FILTER_BLUE  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2,
        ST_STORE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        COL_RED   = 2'd0,
        COL_GREEN = 2'd1,
        COL_BLUE  = 2'd2
    } col_t;

    function automatic logic [1:0] filter_sel(input col_t col);
        case (col)
            COL_GREEN: return FILTER_GREEN;
            COL_BLUE:  return FILTER_BLUE;
            default:   return FILTER_RED;
        endcase
    endfunction

endpackage

// File: rtl/color_sensor_sampler_edge_sync.sv
// Brings the asynchronous sensor square wave into the clk domain and emits a
// one-cycle pulse per rising edge, three cycles after the edge.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    // Two-flop synchroniser, delayed copy, and registered rising-edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            prev_q  <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync_q1 <= async_in;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
            pulse   <= sync_q2 & ~prev_q;
        end
    end

endmodule

// File: rtl/color_sensor_sampler.sv
// TCS3200-style colour sensor front end: steps the filter red/green/blue,
// counts sensor edges over a gate window per colour, and publishes one
// clamped 8-bit R/G/B triple per frame.
module color_sensor_sampler #(
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned GATE_CYCLES   = 50000,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned SCALE_SHIFT   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sensor_out,
    output logic       s2,
    output logic       s3,
    output logic       oe_n,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       valid,
    output logic       busy
);

    import color_defs::*;

    localparam int unsigned TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    col_t             col;
    col_t             col_nxt;
    logic [TMR_W-1:0] timer;
    logic             timer_clr;
    logic             publish;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] scaled;
    logic [7:0]       value;
    logic [7:0]       shadow_r;
    logic [7:0]       shadow_g;
    logic             edge_pulse;

    edge_sync u_edge_sync (
        .clk      (clk),
        .rst_n    (rst),
        .async_in (sensor_out),
        .pulse    (edge_pulse)
    );

    assign scaled = cnt >> SCALE_SHIFT;
    assign value  = (scaled > CNT_W'(255)) ? 8'hFF : scaled[7:0];

    // State and colour index registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            col   <= COL_RED;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
        end
    end

    // Next-state decode, phase timer control and sensor-facing outputs
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        timer_clr = 1'b0;
        publish   = 1'b0;
        busy      = (state != ST_IDLE);
        oe_n      = (state == ST_IDLE);
        {s2, s3}  = (state == ST_IDLE) ? FILTER_RED : filter_sel(col);
        case (state)
            ST_IDLE: begin
                timer_clr = 1'b1;
                if (en) begin
                    state_nxt = ST_SETTLE;
                    col_nxt   = COL_RED;
                end
            end
            ST_SETTLE: begin
                if (timer == SETTLE_LAST) begin
                    state_nxt = ST_GATE;
                    timer_clr = 1'b1;
                end
            end
            ST_GATE: begin
                if (timer == GATE_LAST) begin
                    state_nxt = ST_STORE;
                    timer_clr = 1'b1;
                end
            end
            ST_STORE: begin
                timer_clr = 1'b1;
                state_nxt = ST_SETTLE;
                case (col)
                    COL_RED:   col_nxt = COL_GREEN;
                    COL_GREEN: col_nxt = COL_BLUE;
                    default: begin
                        publish   = 1'b1;
                        col_nxt   = COL_RED;
                        state_nxt = en ? ST_SETTLE : ST_IDLE;
                    end
                endcase
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Phase timer: counts cycles spent in the current SETTLE or GATE phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (timer_clr) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Saturating edge counter, live only during GATE and held through STORE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state != ST_GATE) begin
            cnt <= '0;
        end else if (edge_pulse && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shadow capture per colour; the triple is published together on BLUE STORE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_r <= '0;
            shadow_g <= '0;
            R        <= '0;
            G        <= '0;
            B        <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= publish;
            if (state == ST_STORE) begin
                if (col == COL_RED)   shadow_r <= value;
                if (col == COL_GREEN) shadow_g <= value;
            end
            if (publish) begin
                R <= shadow_r;
                G <= shadow_g;
                B <= value;
            end
        end
    end

endmodule

// File: tb/tb_color_sensor_sampler.sv
// Self-checking bench for color_sensor_sampler: a clock-synchronous sensor
// model keyed on the DUT filter select, a scoreboard of expected triples
// popped on each valid pulse, and one task per scenario.
module tb_color_sensor_sampler;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic sensor_out = 1'b0;
    logic en_sat = 1'b0;
    logic sensor_sat = 1'b0;

    logic s2, s3, oe_n, valid, busy;
    logic [7:0] R, G, B;

    logic s2_a, s3_a, oe_n_a, valid_a, busy_a;
    logic [7:0] r_a, g_a, b_a;
    logic s2_b, s3_b, oe_n_b, valid_b, busy_b;
    logic [7:0] r_b, g_b, b_b;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    rgb_t exp_q[$];

    int unsigned period[3];
    int          trig[3];
    bit          custom = 1'b0;

    color_sensor_sampler #(
        .SETTLE_CYCLES(4), .GATE_CYCLES(100), .CNT_W(16), .SCALE_SHIFT(0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sensor_out(sensor_out),
        .s2(s2), .s3(s3), .oe_n(oe_n), .R(R), .G(G), .B(B),
        .valid(valid), .busy(busy)
    );

    color_sensor_sampler #(
        .SETTLE_CYCLES(4), .GATE_CYCLES(1000), .CNT_W(16), .SCALE_SHIFT(0)
    ) dut_sat0 (
        .clk(clk), .rst(rst), .en(en_sat), .sensor_out(sensor_sat),
        .s2(s2_a), .s3(s3_a), .oe_n(oe_n_a), .R(r_a), .G(g_a), .B(b_a),
        .valid(valid_a), .busy(busy_a)
    );

    color_sensor_sampler #(
        .SETTLE_CYCLES(4), .GATE_CYCLES(1000), .CNT_W(16), .SCALE_SHIFT(2)
    ) dut_sat2 (
        .clk(clk), .rst(rst), .en(en_sat), .sensor_out(sensor_sat),
        .s2(s2_b), .s3(s3_b), .oe_n(oe_n_b), .R(r_b), .G(g_b), .B(b_b),
        .valid(valid_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Sensor model: restarts its waveform whenever the filter or enable changes
    initial begin
        int unsigned oc;
        logic [2:0]  sel;
        logic [2:0]  prev_sel;
        int          idx;
        oc = 0;
        prev_sel = 3'b100;
        forever begin
            @(negedge clk);
            sel = {oe_n, s2, s3};
            if (oe_n !== 1'b0) begin
                sensor_out = 1'b0;
                oc = 0;
            end else begin
                if (sel != prev_sel) oc = 0;
                else oc++;
                idx = ({s2, s3} == 2'b11) ? 1 : (({s2, s3} == 2'b01) ? 2 : 0);
                if (custom) sensor_out = (int'(oc) == trig[idx]);
                else if (period[idx] == 0) sensor_out = 1'b0;
                else sensor_out = ((oc % period[idx]) < (period[idx] / 2));
            end
            prev_sel = sel;
        end
    end

    // Free-running period-2 sensor for the long-gate instances
    initial begin
        forever begin
            @(negedge clk);
            sensor_sat = ~sensor_sat;
        end
    end

    // Scoreboard: every valid pulse on the main DUT must match the next expected triple
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid got RGB=%h expected no valid", {R, G, B});
            end else begin
                rgb_t e;
                e = exp_q.pop_front();
                if ({R, G, B} !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard_rgb got %h expected %h", {R, G, B}, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        en = 1'b0;
        en_sat = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_periods(input int unsigned pr, input int unsigned pg, input int unsigned pb);
        period[0] = pr;
        period[1] = pg;
        period[2] = pb;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({R, G, B, valid, busy, s2, s3, oe_n} !== {24'h0, 1'b0, 1'b0, 2'b00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_main got %h expected %h", {R, G, B, valid, busy, s2, s3, oe_n},
                     {24'h0, 1'b0, 1'b0, 2'b00, 1'b1});
        end
        n_checks++;
        if ({r_a, g_a, b_a, valid_a, busy_a, oe_n_a} !== {24'h0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_sat got %h expected %h", {r_a, g_a, b_a, valid_a, busy_a, oe_n_a},
                     {24'h0, 1'b0, 1'b0, 1'b1});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        int lat;
        logic [1:0] seen[$];
        bit oe_bad;
        lat = -1;
        oe_bad = 1'b0;
        custom = 1'b0;
        set_periods(10, 10, 10);
        apply_reset();
        @(negedge clk);
        en = 1'b1;
        exp_q.push_back('{8'd10, 8'd10, 8'd10});
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) en = 1'b0;
            if (busy === 1'b1) begin
                if (oe_n !== 1'b0) oe_bad = 1'b1;
                if (seen.size() == 0 || seen[seen.size() - 1] != {s2, s3}) seen.push_back({s2, s3});
            end
            if (valid === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
        n_checks++;
        if (lat != 315) begin
            n_fail++;
            $display("FAIL basic_latency got %0d expected 315", lat);
        end
        n_checks++;
        if (seen.size() != 3 || {seen[0], seen[1], seen[2]} !== 6'b00_11_01) begin
            n_fail++;
            $display("FAIL basic_filter_seq got %0d steps %b expected 3 steps 001101",
                     seen.size(), (seen.size() == 3) ? {seen[0], seen[1], seen[2]} : 6'bx);
        end
        n_checks++;
        if (oe_bad) begin
            n_fail++;
            $display("FAIL basic_oe_n got 1 while busy expected 0");
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, oe_n} !== 2'b01 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_idle got busy/oe_n=%b pending=%0d expected 01 pending=0",
                     {busy, oe_n}, exp_q.size());
        end
    endtask

    task automatic test_rates();
        int lat;
        int nvalid;
        lat = -1;
        nvalid = 0;
        set_periods(5, 10, 20);
        apply_reset();
        @(negedge clk);
        en = 1'b1;
        exp_q.push_back('{8'd20, 8'd10, 8'd5});
        for (int n = 1; n <= 340; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) en = 1'b0;
            if (valid === 1'b1) begin
                nvalid++;
                if (lat < 0) lat = n - 1;
            end
        end
        n_checks++;
        if (nvalid != 1 || lat != 315) begin
            n_fail++;
            $display("FAIL rates_valid got %0d pulses first at %0d expected 1 at 315", nvalid, lat);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rates_pending got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_saturation();
        int lat;
        logic [23:0] rgb0;
        logic [23:0] rgb2;
        logic v2;
        lat = -1;
        rgb0 = 'x;
        rgb2 = 'x;
        v2 = 1'b0;
        apply_reset();
        @(negedge clk);
        en_sat = 1'b1;
        for (int n = 1; n <= 3100; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) en_sat = 1'b0;
            if (valid_a === 1'b1) begin
                lat = n - 1;
                rgb0 = {r_a, g_a, b_a};
                rgb2 = {r_b, g_b, b_b};
                v2 = valid_b;
                break;
            end
        end
        n_checks++;
        if (lat != 3015) begin
            n_fail++;
            $display("FAIL sat_latency got %0d expected 3015", lat);
        end
        n_checks++;
        if (rgb0 !== 24'hFFFFFF) begin
            n_fail++;
            $display("FAIL sat_clamp got %h expected ffffff", rgb0);
        end
        n_checks++;
        if (rgb2 !== 24'h7D7D7D || v2 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_shift2 got %h valid=%b expected 7d7d7d valid=1", rgb2, v2);
        end
    endtask

    task automatic test_en_drop();
        bit found;
        int nvalid;
        found = 1'b0;
        nvalid = 0;
        set_periods(10, 10, 10);
        apply_reset();
        @(negedge clk);
        en = 1'b1;
        exp_q.push_back('{8'd10, 8'd10, 8'd10});
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        set_periods(5, 10, 20);
        exp_q.push_back('{8'd20, 8'd10, 8'd5});
        for (int n = 1; n <= 200 && found; n++) begin
            @(posedge clk);
            #1;
            if ({s2, s3} == 2'b11) break;
        end
        repeat (30) @(posedge clk);
        #1;
        en = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                nvalid++;
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (nvalid != 1 || !found) begin
            n_fail++;
            $display("FAIL endrop_valid got %0d final pulses (frame1 seen=%0d) expected 1", nvalid, found);
        end
        n_checks++;
        if ({busy, oe_n} !== 2'b01) begin
            n_fail++;
            $display("FAIL endrop_idle got busy/oe_n=%b expected 01", {busy, oe_n});
        end
        nvalid = 0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) nvalid++;
        end
        n_checks++;
        if (nvalid != 0 || {R, G, B} !== 24'h140A05) begin
            n_fail++;
            $display("FAIL endrop_hold got RGB=%h pulses=%0d expected 140a05 pulses=0", {R, G, B}, nvalid);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int lat;
        found = 1'b0;
        lat = -1;
        set_periods(10, 10, 10);
        apply_reset();
        @(negedge clk);
        en = 1'b1;
        exp_q.push_back('{8'd10, 8'd10, 8'd10});
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) break;
        end
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if ({s2, s3} == 2'b01) begin
                found = 1'b1;
                break;
            end
        end
        repeat (50) @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        n_checks++;
        if (!found || {R, G, B, valid, busy, s2, s3, oe_n} !== {24'h0, 1'b0, 1'b0, 2'b00, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_outputs got %h (blue seen=%0d) expected %h",
                     {R, G, B, valid, busy, s2, s3, oe_n}, found, {24'h0, 1'b0, 1'b0, 2'b00, 1'b1});
        end
        repeat (2) @(negedge clk);
        exp_q.push_back('{8'd10, 8'd10, 8'd10});
        rst = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) en = 1'b0;
            if (valid === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
        n_checks++;
        if (lat != 315) begin
            n_fail++;
            $display("FAIL midreset_latency got %0d expected 315", lat);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_settle_gate_edges();
        int lat;
        lat = -1;
        custom = 1'b1;
        trig[0] = 0;
        trig[1] = 100;
        trig[2] = 101;
        apply_reset();
        @(negedge clk);
        en = 1'b1;
        exp_q.push_back('{8'd0, 8'd1, 8'd0});
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) en = 1'b0;
            if (valid === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (lat != 315 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL edges_frame got latency %0d pending %0d expected 315 pending 0", lat, exp_q.size());
        end
        custom = 1'b0;
    endtask

    initial begin
        set_periods(10, 10, 10);
        trig[0] = -1;
        trig[1] = -1;
        trig[2] = -1;
        test_reset();
        test_basic_frame();
        test_rates();
        test_saturation();
        test_en_drop();
        test_reset_mid();
        test_settle_gate_edges();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
